// File: rtl/issue_stage.sv
// In-order issue stage: FIFO of decoded ops, scoreboard lock handshake, execute dispatch.
// Optional stall statistics are enabled with the ISSUE_STATS_EN macro.
module issue_stage #(
  parameter int DEPTH      = 4,
  parameter int REG_ADDR_W = 5,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic [XLEN-1:0]       dec_payload,
  output logic [REG_ADDR_W-1:0] sb_target,
  output logic [REG_ADDR_W-1:0] sb_source1,
  output logic [REG_ADDR_W-1:0] sb_source2,
  output logic                  sb_lock,
  input  logic                  sb_exec_ok,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [XLEN-1:0]       ex_payload,
  input  logic                  flush,
  output logic                  rel_valid,
  output logic [REG_ADDR_W-1:0] rel_addr,
  output logic [31:0]           stall_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = 3 * REG_ADDR_W + XLEN;
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LOCK, DISPATCH} state_t;

  state_t           state;
  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [REG_ADDR_W-1:0] head_rs1;
  logic [REG_ADDR_W-1:0] head_rs2;
  logic [XLEN-1:0]       head_payload;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign dec_ready = !full;
  assign push      = dec_valid && !full && !flush;
  assign pop       = (state == LOCK) && sb_exec_ok && !flush;

  assign {head_rd, head_rs1, head_rs2, head_payload} = mem[rd_ptr[PTR_W-1:0]];

  assign sb_target  = head_rd;
  assign sb_source1 = head_rs1;
  assign sb_source2 = head_rs2;

  // Suppressed during flush so the scoreboard never grants a lock nobody will track.
  assign sb_lock = (state == IDLE) && !empty && !flush;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[PTR_W-1:0]] <= {dec_rd, dec_rs1, dec_rs2, dec_payload};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // A grant in LOCK (or an op in DISPATCH) means the scoreboard holds a lock; flush orphans it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ex_valid   <= 1'b0;
      ex_rd      <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_payload <= '0;
      rel_valid  <= 1'b0;
      rel_addr   <= '0;
    end else begin
      rel_valid <= 1'b0;
      if (flush) begin
        state    <= IDLE;
        ex_valid <= 1'b0;
        if (state == DISPATCH) begin
          rel_valid <= 1'b1;
          rel_addr  <= ex_rd;
        end else if (state == LOCK && sb_exec_ok) begin
          rel_valid <= 1'b1;
          rel_addr  <= head_rd;
        end
      end else begin
        case (state)
          IDLE: begin
            if (!empty) state <= LOCK;
          end
          LOCK: begin
            if (sb_exec_ok) begin
              ex_rd      <= head_rd;
              ex_rs1     <= head_rs1;
              ex_rs2     <= head_rs2;
              ex_payload <= head_payload;
              ex_valid   <= 1'b1;
              state      <= DISPATCH;
            end else begin
              state <= IDLE;
            end
          end
          DISPATCH: begin
            if (ex_ready) begin
              ex_valid <= 1'b0;
              state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef ISSUE_STATS_EN
  logic [31:0] stall_q;

  // Counts scoreboard denials; saturates rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= '0;
    else if (state == LOCK && !sb_exec_ok && !flush && stall_q != 32'hFFFF_FFFF)
      stall_q <= stall_q + 32'd1;
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_issue_stage.sv
// Self-checking bench for issue_stage: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level queue model.
module tb_issue_stage;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        dec_valid;
  logic        dec_ready;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [31:0] dec_payload;
  logic [4:0]  sb_target, sb_source1, sb_source2;
  logic        sb_lock;
  logic        sb_exec_ok;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic [31:0] ex_payload;
  logic        flush;
  logic        rel_valid;
  logic [4:0]  rel_addr;
  logic [31:0] stall_count;

  int nChecks = 0;
  int nPass   = 0;

  issue_stage #(.DEPTH(DEPTH), .REG_ADDR_W(5), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_payload(dec_payload),
    .sb_target(sb_target), .sb_source1(sb_source1), .sb_source2(sb_source2),
    .sb_lock(sb_lock), .sb_exec_ok(sb_exec_ok),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_payload(ex_payload),
    .flush(flush), .rel_valid(rel_valid), .rel_addr(rel_addr),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
  endtask

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] pay;
  } op_t;

  // Reference model: ops waiting, the op being dispatched, and where the head is in
  // its lock/grant/dispatch lifecycle (0 = waiting to request, 1 = awaiting grant, 2 = dispatching).
  op_t         mq[$];
  op_t         mex;
  int          mphase;
  bit          mrel;
  logic [4:0]  mrelAddr;
  logic [31:0] mstall;

  task automatic modelReset();
    mq.delete();
    mphase = 0;
    mrel   = 1'b0;
    mstall = '0;
  endtask

  initial modelReset();

  always @(negedge clk) begin
    if (!rst_n) begin
      modelReset();
      checkOutput("rst_dec_ready", dec_ready, 1);
      checkOutput("rst_sb_lock", sb_lock, 0);
      checkOutput("rst_ex_valid", ex_valid, 0);
      checkOutput("rst_rel_valid", rel_valid, 0);
      checkOutput("rst_stall", stall_count, 0);
      checkOutput("rst_ex_fields", {ex_rd, ex_rs1, ex_rs2, ex_payload}, 0);
      checkOutput("rst_rel_addr", rel_addr, 0);
    end else begin
      bit accept;
      bit nrel;
      checkOutput("dec_ready", dec_ready, mq.size() < DEPTH);
      checkOutput("sb_lock", sb_lock, (mphase == 0) && (mq.size() > 0) && !flush);
      checkOutput("ex_valid", ex_valid, mphase == 2);
      checkOutput("rel_valid", rel_valid, mrel);
      if (mrel) checkOutput("rel_addr", rel_addr, mrelAddr);
      if (mq.size() > 0)
        checkOutput("sb_ids", {sb_target, sb_source1, sb_source2}, {mq[0].rd, mq[0].rs1, mq[0].rs2});
      if (mphase == 2)
        checkOutput("ex_op", {ex_rd, ex_rs1, ex_rs2, ex_payload}, mex);
`ifdef ISSUE_STATS_EN
      checkOutput("stall_count", stall_count, mstall);
`else
      checkOutput("stall_count", stall_count, 0);
`endif
      accept = dec_valid && (mq.size() < DEPTH);
      nrel   = 1'b0;
      if (flush) begin
        if (mphase == 2) begin
          nrel = 1'b1;
          mrelAddr = mex.rd;
        end else if (mphase == 1 && sb_exec_ok) begin
          nrel = 1'b1;
          mrelAddr = mq[0].rd;
        end
        mq.delete();
        mphase = 0;
      end else begin
        if (mphase == 0) begin
          if (mq.size() > 0) mphase = 1;
        end else if (mphase == 1) begin
          if (sb_exec_ok) begin
            mex = mq.pop_front();
            mphase = 2;
          end else begin
            mphase = 0;
            if (mstall != 32'hFFFF_FFFF) mstall = mstall + 1;
          end
        end else if (ex_ready) begin
          mphase = 0;
        end
        if (accept) mq.push_back('{rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2, pay: dec_payload});
      end
      mrel = nrel;
    end
  end

  task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] pay,
                               input logic ok, input logic exr, input logic fl);
    dec_valid   = v;
    dec_rd      = rd;
    dec_rs1     = rs1;
    dec_rs2     = rs2;
    dec_payload = pay;
    sb_exec_ok  = ok;
    ex_ready    = exr;
    flush       = fl;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) stepCycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    doReset();

    // Single op, uncontended: lock request in cycle 1, dispatch in cycle 3.
    applyStimulus(1, 5, 1, 2, 32'hDEAD_BEEF, 1, 1, 0);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0);
    @(negedge clk);
    checkOutput("lat_sb_lock", sb_lock, 1);
    checkOutput("lat_sb_target", sb_target, 5);
    stepCycle();
    @(negedge clk);
    checkOutput("lat_no_ex_c2", ex_valid, 0);
    stepCycle();
    @(negedge clk);
    checkOutput("lat_ex_valid", ex_valid, 1);
    checkOutput("lat_ex_rd", ex_rd, 5);
    checkOutput("lat_ex_payload", ex_payload, 32'hDEAD_BEEF);
    stepCycle();
    stepCycle();

    // Fill with ex_ready low: the fifth push still fits, then dec_ready falls.
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 5'(10 + i), 5'(i), 5'(i + 1), 32'h1000 + i, 1, 0, 0);
      @(negedge clk);
      if (i == 3) checkOutput("fill_ex_valid", ex_valid, 1);
      if (i == 4) checkOutput("fill_ready_before_5th", dec_ready, 1);
      stepCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("fill_ready_after_5th", dec_ready, 0);
    checkOutput("fill_ex_rd", ex_rd, 10);
    stepCycle();

    // Three denials then a grant: sb_lock every other cycle.
    doReset();
    applyStimulus(1, 9, 3, 4, 32'hCAFE_0009, 0, 1, 0);
    stepCycle();
    for (int a = 0; a < 4; a++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      @(negedge clk);
      checkOutput("deny_sb_lock", sb_lock, 1);
      stepCycle();
      applyStimulus(0, 0, 0, 0, 0, (a == 3), 1, 0);
      @(negedge clk);
      checkOutput("deny_lock_gap", sb_lock, 0);
      stepCycle();
    end
    @(negedge clk);
    checkOutput("deny_ex_valid", ex_valid, 1);
    checkOutput("deny_ex_rd", ex_rd, 9);
`ifdef ISSUE_STATS_EN
    checkOutput("deny_stall_count", stall_count, 3);
`endif
    stepCycle();

    // Flush while dispatching rd=7: lock reported as orphaned.
    doReset();
    applyStimulus(1, 7, 1, 1, 32'h7777, 1, 0, 0);
    stepCycle();
    applyStimulus(1, 8, 2, 2, 32'h8888, 1, 0, 0);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);
    @(negedge clk);
    checkOutput("flush_pre_ex_valid", ex_valid, 1);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("flush_ex_valid", ex_valid, 0);
    checkOutput("flush_rel_valid", rel_valid, 1);
    checkOutput("flush_rel_addr", rel_addr, 7);
    checkOutput("flush_empty_lock", sb_lock, 0);
    stepCycle();
    @(negedge clk);
    checkOutput("flush_rel_pulse", rel_valid, 0);
    stepCycle();

    // Reset asserted while in LOCK with two ops buffered.
    doReset();
    applyStimulus(1, 3, 1, 1, 32'h3333, 1, 1, 0);
    stepCycle();
    applyStimulus(1, 4, 1, 1, 32'h4444, 1, 1, 0);
    stepCycle();
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0);
    @(negedge clk);
    checkOutput("midrst_dec_ready", dec_ready, 1);
    checkOutput("midrst_rel_valid", rel_valid, 0);
    stepCycle();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postrst_rel_valid", rel_valid, 0);
    checkOutput("postrst_sb_lock", sb_lock, 0);
    stepCycle();

    // Randomized traffic; the model checks order, handshakes, flush and reset each cycle.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      applyStimulus($urandom_range(0, 99) < 60, 5'($urandom), 5'($urandom), 5'($urandom),
                    $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 99) < 4);
      stepCycle();
    end
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0);
    repeat (10) stepCycle();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
